// File: rtl/axis_insert_header_pkg.sv
// Shared types and byte-count helpers for axi_stream_insert_header.
package axis_insert_header_pkg;

  // Widest keep vector the helpers accept (512-bit data bus).
  localparam int KEEP_MAX = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  function automatic logic [7:0] keep_to_cnt(input logic [KEEP_MAX-1:0] keep);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_MAX; i++) cnt = cnt + 8'(keep[i]);
    return cnt;
  endfunction

  // Top cnt bits of an nbytes-wide mask set; bits at and above nbytes stay clear.
  function automatic logic [KEEP_MAX-1:0] cnt_to_keep_msb(input int cnt, input int nbytes);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_MAX; i++) m[i] = (i < nbytes) && (i >= nbytes - cnt);
    return m;
  endfunction

endpackage

// File: rtl/axi_stream_insert_header_if.sv
// Bus bundle for axi_stream_insert_header: input stream, output stream and header side-band.
// Handshake: a beat moves on a rising clk edge where valid and ready are both high; while valid is
// high and ready low the source holds valid and its payload stable, and valid never waits on ready.
interface axi_stream_insert_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                    valid_in;
  logic                    ready_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;

  logic                    valid_out;
  logic                    ready_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;

  logic                    valid_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;

  modport slave (
    input  valid_in, data_in, keep_in, last_in, ready_out,
    input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
    output ready_in, valid_out, data_out, keep_out, last_out
  );

  modport master (
    output valid_in, data_in, keep_in, last_in, ready_out,
    output valid_insert, data_insert, keep_insert, byte_insert_cnt,
    input  ready_in, valid_out, data_out, keep_out, last_out
  );
endinterface

// File: rtl/axis_byte_merge.sv
// Combinational byte realignment: residue bytes followed by the leading bytes of data_in.
module axis_byte_merge #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int LEN_WD       = 3
) (
  input  logic [LEN_WD-1:0]  hdr_len,
  input  logic [DATA_WD-1:0] residue,
  input  logic [DATA_WD-1:0] data_in,
  output logic [DATA_WD-1:0] merged,
  output logic [DATA_WD-1:0] new_residue
);
  int lo_sh;
  int hi_sh;

  assign lo_sh = 8 * int'(hdr_len);
  assign hi_sh = 8 * (DATA_BYTE_WD - int'(hdr_len));

  // Shifts of a full word width yield zero, which covers hdr_len of 0 and DATA_BYTE_WD.
  assign merged      = (residue << hi_sh) | (data_in >> lo_sh);
  assign new_residue = data_in & ~({DATA_WD{1'b1}} << lo_sh);
endmodule

// File: rtl/axi_stream_insert_header.sv
// Prepends a 0..DATA_BYTE_WD byte header to each AXI-Stream packet and realigns the payload.
// Define AXIS_INSERT_HDR_CHECK_EN to compile in simulation-only protocol checks.
module axi_stream_insert_header
  import axis_insert_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic   clk,
  input  logic   rst_n,
  axi_stream_insert_header_if.slave bus,
  output state_t state_dbg
);
  localparam int HW = BYTE_CNT_WD + 1;
  localparam logic [HW:0] FULL_CNT = (HW + 1)'(DATA_BYTE_WD);

  state_t                  state;
  logic [HW-1:0]           hdr_len, drain_cnt, hdr_sample, h_cur, k_in;
  logic [HW:0]             total;
  logic [DATA_WD-1:0]      residue, res_cur, merged, new_res;
  logic [DATA_BYTE_WD-1:0] last_keep, drain_keep;
  logic                    accept, out_free;

  logic                    valid_q, last_q;
  logic [DATA_WD-1:0]      data_q;
  logic [DATA_BYTE_WD-1:0] keep_q;

  logic                    unused_cnt;
  assign unused_cnt = ^bus.byte_insert_cnt;

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

  assign out_free    = !valid_q || bus.ready_out;
  assign bus.ready_in = (state != DRAIN) && out_free;
  assign accept      = bus.valid_in && bus.ready_in;

  // Header length is live only while a packet's first beat is being accepted.
  assign hdr_sample = (bus.valid_insert && (|bus.keep_insert))
                    ? HW'(keep_to_cnt(KEEP_MAX'(bus.keep_insert))) : '0;
  assign h_cur      = (state == IDLE) ? hdr_sample : hdr_len;
  assign res_cur    = (state == IDLE) ? bus.data_insert : residue;
  assign k_in       = HW'(keep_to_cnt(KEEP_MAX'(bus.keep_in)));
  assign total      = {1'b0, h_cur} + {1'b0, k_in};
  assign last_keep  = DATA_BYTE_WD'(cnt_to_keep_msb(int'(total), DATA_BYTE_WD));
  assign drain_keep = DATA_BYTE_WD'(cnt_to_keep_msb(int'(drain_cnt), DATA_BYTE_WD));

  // In DRAIN the data_in bytes land beyond drain_keep and are masked off.
  axis_byte_merge #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .LEN_WD       (HW)
  ) u_merge (
    .hdr_len     (h_cur),
    .residue     (res_cur),
    .data_in     (bus.data_in),
    .merged      (merged),
    .new_residue (new_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hdr_len   <= '0;
      drain_cnt <= '0;
      residue   <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      keep_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      if (valid_q && bus.ready_out) valid_q <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          if (accept) begin
            valid_q <= 1'b1;
            hdr_len <= h_cur;
            residue <= new_res;
            if (!bus.last_in) begin
              data_q <= merged;
              keep_q <= '1;
              last_q <= 1'b0;
              state  <= STREAM;
            end else if (total <= FULL_CNT) begin
              data_q <= merged & byte_mask(last_keep);
              keep_q <= last_keep;
              last_q <= 1'b1;
              state  <= IDLE;
            end else begin
              data_q    <= merged;
              keep_q    <= '1;
              last_q    <= 1'b0;
              drain_cnt <= HW'(total - FULL_CNT);
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_free) begin
            valid_q <= 1'b1;
            data_q  <= merged & byte_mask(drain_keep);
            keep_q  <= drain_keep;
            last_q  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.keep_out  = keep_q;
  assign bus.last_out  = last_q;
  assign state_dbg     = state;

`ifdef AXIS_INSERT_HDR_CHECK_EN
  logic                            stall_q;
  logic [DATA_WD+DATA_BYTE_WD+1:0] out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
      out_q   <= '0;
    end else begin
      stall_q <= valid_q && !bus.ready_out;
      out_q   <= {valid_q, data_q, keep_q, last_q};
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (accept && state == IDLE && bus.valid_insert) begin
        if (((bus.keep_insert + DATA_BYTE_WD'(1)) & bus.keep_insert) != '0)
          $error("keep_insert not contiguous: %b", bus.keep_insert);
        if (bus.byte_insert_cnt != BYTE_CNT_WD'(hdr_sample))
          $error("byte_insert_cnt %0d disagrees with header length %0d", bus.byte_insert_cnt, hdr_sample);
      end
      if (accept && !bus.last_in && !(&bus.keep_in))
        $error("partial keep_in %b on a non-last beat", bus.keep_in);
      if (stall_q && ({valid_q, data_q, keep_q, last_q} != out_q))
        $error("output changed while stalled");
    end
  end
`else
  // Checks compile away; the datapath is unaffected.
`endif

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Bench for axi_stream_insert_header: directed cases plus randomized packets against a byte-queue model.
module tb_axi_stream_insert_header;
  import axis_insert_header_pkg::*;

  localparam int DW = 32;
  localparam int NB = 4;
  localparam int CW = 2;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t state_dbg;

  axi_stream_insert_header_if #(.DATA_WD(DW)) bus ();

  axi_stream_insert_header #(.DATA_WD(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [DW+NB:0]  exp_q[$];   // {data, keep, last}
  logic [DW-1:0]   pl_data[$];
  logic [NB-1:0]   pl_keep[$];

  // Header bytes then payload bytes form one byte stream, re-chopped into NB-byte beats.
  task automatic model_packet(input int h, input logic [DW-1:0] hdr);
    logic [7:0] bytes[$];
    logic [DW-1:0] w;
    logic [NB-1:0] k;
    for (int j = h - 1; j >= 0; j--) bytes.push_back(hdr[8*j +: 8]);
    foreach (pl_data[b])
      for (int i = 0; i < NB; i++)
        if (pl_keep[b][NB-1-i]) bytes.push_back(pl_data[b][DW-1-8*i -: 8]);
    for (int s = 0; s < bytes.size(); s += NB) begin
      w = '0;
      k = '0;
      for (int i = 0; i < NB && s + i < bytes.size(); i++) begin
        w[DW-1-8*i -: 8] = bytes[s+i];
        k[NB-1-i] = 1'b1;
      end
      exp_q.push_back({w, k, (s + NB >= bytes.size())});
    end
  endtask

  // ---------------- drivers ----------------
  bit lat_chk   = 1'b0;
  int stall_cnt = 0;
  bit bp_rand   = 1'b0;
  bit mon_en    = 1'b0;
  bit done      = 1'b0;

  initial begin
    bus.ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        bus.ready_out = 1'b0;
        stall_cnt--;
      end else begin
        bus.ready_out = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input bit last);
    int waitc;
    waitc = 0;
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.keep_in  = k;
    bus.last_in  = last;
    @(negedge clk);
    if (lat_chk) check_eq("lat_before_accept", 64'(bus.valid_out), 64'(0));
    while (!bus.ready_in && waitc < 200) begin
      waitc++;
      @(negedge clk);
    end
    check_eq("accept_within_bound", 64'(waitc < 200), 64'(1));
    @(posedge clk);
    #1;
    if (lat_chk) begin
      check_eq("lat_after_accept", 64'(bus.valid_out), 64'(1));
      lat_chk = 1'b0;
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic send_packet(input logic vi, input logic [DW-1:0] di, input logic [NB-1:0] ki, input bit gaps);
    int h;
    h = (vi && ki != '0) ? $countones(ki) : 0;
    model_packet(h, di);
    bus.valid_insert    = vi;
    bus.data_insert     = di;
    bus.keep_insert     = ki;
    bus.byte_insert_cnt = CW'($countones(ki) % NB);
    foreach (pl_data[b]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      drive_beat(pl_data[b], pl_keep[b], (b == pl_data.size() - 1));
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check_eq("queue_drained", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  bit prev_stall = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check_eq("hold_valid", 64'(bus.valid_out), 64'(1));
        if (bus.valid_out) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_beat_queue_size", 64'(exp_q.size()), 64'(1));
          end else begin
            check_eq("out_beat", 64'({bus.data_out, bus.keep_out, bus.last_out}), 64'(exp_q[0]));
            if (bus.ready_out) void'(exp_q.pop_front());
          end
          if (!bus.ready_out) check_eq("ready_in_stalled", 64'(bus.ready_in), 64'(0));
        end
        prev_stall = bus.valid_out && !bus.ready_out;
      end
    end
  end

  initial begin
    #500000;
    check_eq("watchdog_done", 64'(done), 64'(1));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  logic [NB-1:0] full;
  int            nb, hl, kl;
  logic          rvi;
  logic [DW-1:0] rdi;
  logic [NB-1:0] rki;

  initial begin
    full                = '1;
    bus.valid_in        = 1'b0;
    bus.data_in         = '0;
    bus.keep_in         = '0;
    bus.last_in         = 1'b0;
    bus.valid_insert    = 1'b0;
    bus.data_insert     = '0;
    bus.keep_insert     = '0;
    bus.byte_insert_cnt = '0;
    rst_n               = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_valid_out", 64'(bus.valid_out), 64'(0));
    check_eq("rst_last_out", 64'(bus.last_out), 64'(0));
    check_eq("rst_data_out", 64'(bus.data_out), 64'(0));
    check_eq("rst_keep_out", 64'(bus.keep_out), 64'(0));
    check_eq("rst_ready_in", 64'(bus.ready_in), 64'(1));
    check_eq("rst_state", 64'(state_dbg), 64'(IDLE));
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Partial header, two beats, ends with a drain beat.
    pl_data = '{32'h12345678, 32'h9ABCDEF0};
    pl_keep = '{4'hF, 4'hC};
    lat_chk = 1'b1;
    send_packet(1'b1, 32'h00A5B6C7, 4'b0111, 1'b0);
    wait_idle();

    // Full-word header on a single-beat packet.
    pl_data = '{32'h12345678};
    pl_keep = '{4'hF};
    send_packet(1'b1, 32'hA5A5A5A5, 4'b1111, 1'b0);
    wait_idle();

    // One-byte header fills a short beat exactly.
    pl_data = '{32'h11223300};
    pl_keep = '{4'hE};
    send_packet(1'b1, 32'h000000EE, 4'b0001, 1'b0);
    wait_idle();

    // No header: pass-through.
    pl_data = '{32'h11111111, 32'h22222222, 32'h33000000};
    pl_keep = '{4'hF, 4'hF, 4'h8};
    send_packet(1'b0, 32'h00000000, 4'b0000, 1'b0);
    wait_idle();

    // Backpressure in the middle of a packet.
    pl_data = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0000};
    pl_keep = '{4'hF, 4'hF, 4'hF, 4'hC};
    fork
      send_packet(1'b1, 32'h0000CAFE, 4'b0011, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        stall_cnt = 3;
      end
    join
    wait_idle();

    // Reset while a packet is in STREAM, then a fresh packet.
    mon_en              = 1'b0;
    bus.valid_insert    = 1'b1;
    bus.data_insert     = 32'h000000AB;
    bus.keep_insert     = 4'b0001;
    bus.byte_insert_cnt = 2'd1;
    drive_beat(32'hDEADBEEF, 4'hF, 1'b0);
    check_eq("pre_reset_state", 64'(state_dbg), 64'(STREAM));
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid_out", 64'(bus.valid_out), 64'(0));
    check_eq("midrst_state", 64'(state_dbg), 64'(IDLE));
    check_eq("midrst_ready_in", 64'(bus.ready_in), 64'(1));
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    pl_data = '{32'h44556677};
    pl_keep = '{4'hF};
    send_packet(1'b1, 32'h00112233, 4'b0111, 1'b0);
    wait_idle();

    // Randomized packets, back-to-back, with idle gaps and random backpressure.
    bp_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      nb  = $urandom_range(1, 5);
      hl  = $urandom_range(0, 4);
      kl  = $urandom_range(1, 4);
      rvi = ($urandom_range(0, 5) != 0);
      rdi = $urandom();
      rki = full >> (NB - hl);
      pl_data.delete();
      pl_keep.delete();
      for (int b = 0; b < nb; b++) begin
        pl_data.push_back($urandom());
        pl_keep.push_back((b == nb - 1) ? (full << (NB - kl)) : full);
      end
      send_packet(rvi, rdi, rki, 1'b1);
    end
    wait_idle();
    bp_rand = 1'b0;

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
